// File: rtl/reset_requester.sv
// Always-on reset request front end: turns request levels into a timed active-low
// pulse toward the reset generator and tracks the reset handshake, cause record and count.
module reset_requester #(
  parameter int NUM_SRC        = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int ACK_TIMEOUT    = 1024,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req_src,
  input  logic               sys_rst_n,
  input  logic               cause_clr,
  output logic               rst_req_n,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause,
  output logic               cause_valid,
  output logic               timeout_flag,
  output logic [7:0]         reset_count
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    WAIT_EXIT = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               rst_req_n_nxt, busy_nxt, cause_valid_nxt, timeout_flag_nxt;
  logic [NUM_SRC-1:0] cause_nxt;
  logic [7:0]         reset_count_nxt;
  logic [PW-1:0]      pulse_cnt, pulse_cnt_nxt;
  logic [TW-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic [HW-1:0]      hold_cnt, hold_cnt_nxt;
  logic               entered, entered_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rst_req_n    <= 1'b1;
      busy         <= 1'b0;
      cause        <= '0;
      cause_valid  <= 1'b0;
      timeout_flag <= 1'b0;
      reset_count  <= 8'd0;
      pulse_cnt    <= '0;
      tmo_cnt      <= '0;
      hold_cnt     <= '0;
      entered      <= 1'b0;
    end else begin
      state        <= state_nxt;
      rst_req_n    <= rst_req_n_nxt;
      busy         <= busy_nxt;
      cause        <= cause_nxt;
      cause_valid  <= cause_valid_nxt;
      timeout_flag <= timeout_flag_nxt;
      reset_count  <= reset_count_nxt;
      pulse_cnt    <= pulse_cnt_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
      entered      <= entered_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    rst_req_n_nxt    = rst_req_n;
    cause_nxt        = cause;
    cause_valid_nxt  = cause_valid;
    timeout_flag_nxt = timeout_flag;
    reset_count_nxt  = reset_count;
    pulse_cnt_nxt    = pulse_cnt;
    tmo_cnt_nxt      = tmo_cnt;
    hold_cnt_nxt     = hold_cnt;
    entered_nxt      = entered;

    // Clear first so a same-edge trigger, OR-merge or timeout overrides it.
    if (cause_clr) begin
      cause_nxt        = '0;
      cause_valid_nxt  = 1'b0;
      timeout_flag_nxt = 1'b0;
    end

    if (state != IDLE) begin
      cause_nxt       = cause_nxt | req_src;
      cause_valid_nxt = cause_valid_nxt | (|req_src);
    end

    case (state)
      IDLE: begin
        if (|req_src) begin
          state_nxt       = ASSERT;
          rst_req_n_nxt   = 1'b0;
          cause_nxt       = req_src;
          cause_valid_nxt = 1'b1;
          if (reset_count != 8'hFF) reset_count_nxt = reset_count + 8'd1;
          pulse_cnt_nxt   = PULSE_LAST;
          tmo_cnt_nxt     = '0;
          entered_nxt     = 1'b0;
        end
      end
      ASSERT: begin
        if (pulse_cnt != '0) pulse_cnt_nxt = pulse_cnt - 1'b1;
        if (!sys_rst_n) entered_nxt = 1'b1;
        tmo_cnt_nxt = tmo_cnt + 1'b1;
        if (pulse_cnt == '0 && (entered || !sys_rst_n)) begin
          state_nxt     = WAIT_EXIT;
          rst_req_n_nxt = 1'b1;
          tmo_cnt_nxt   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt        = WAIT_EXIT;
          rst_req_n_nxt    = 1'b1;
          tmo_cnt_nxt      = '0;
          timeout_flag_nxt = 1'b1;
        end
      end
      WAIT_EXIT: begin
        tmo_cnt_nxt = tmo_cnt + 1'b1;
        if (sys_rst_n) begin
          state_nxt    = HOLDOFF;
          hold_cnt_nxt = HOLD_LAST;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt        = HOLDOFF;
          hold_cnt_nxt     = HOLD_LAST;
          timeout_flag_nxt = 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == '0) state_nxt = IDLE;
        else                hold_cnt_nxt = hold_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
